// File: rtl/gnet_remap_pkg.sv
// gnet_remap_pkg
//   Shared definitions for the gate-level net remapper:
//   - 2-bit per-bit mapping modes (CONST0 / CONST1 / PASS / HOLD)
//   - packed map entry {mode, idx}
//   - helpers for select widths and the identity map loaded at reset
package gnet_remap_pkg;

  localparam logic [1:0] MODE_CONST0 = 2'b00;
  localparam logic [1:0] MODE_CONST1 = 2'b01;
  localparam logic [1:0] MODE_PASS   = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  // A package cannot see the instance IN_W, so the source index is sized for
  // the widest supported input (2**16 bits). Only the low $clog2(IN_W) bits
  // are ever nonzero because illegal indices are rejected before storage.
  localparam int MAP_IDX_MAX_W = 16;

  typedef struct packed {
    logic [1:0]               mode;
    logic [MAP_IDX_MAX_W-1:0] idx;
  } map_entry_t;

  // Width of a select field addressing n items (never below one bit).
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Identity map: output bit b follows input bit b where one exists,
  // otherwise it is padded with a constant 0.
  function automatic map_entry_t map_reset_entry(input int bit_pos, input int in_w);
    map_entry_t e;
    if (bit_pos < in_w) begin
      e.mode = MODE_PASS;
      e.idx  = MAP_IDX_MAX_W'(bit_pos);
    end else begin
      e.mode = MODE_CONST0;
      e.idx  = '0;
    end
    return e;
  endfunction

endpackage

// File: rtl/gnet_fifo.sv
// gnet_fifo
//   Small synchronous FIFO with fully registered status and head outputs.
//   Ports:
//     clk, rst_n   clock / asynchronous active-low reset
//     push         write request (ignored while full)
//     push_data    word to store
//     pop          read request (ignored while empty)
//     in_ready     registered "not full"
//     out_valid    registered "not empty"
//     out_data     registered head word; keeps its last value once empty
//     level        current occupancy (0..DEPTH)
module gnet_fifo
  import gnet_remap_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] rd_ptr_inc_s;
  logic [LVL_W-1:0] level_r;
  logic [LVL_W-1:0] level_nxt_s;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] head_nxt_s;
  logic             ready_r;
  logic             valid_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Requests are qualified by the registered flags, so a pop while full
  // never opens a same-cycle push slot.
  assign push_ok_s = push && ready_r;
  assign pop_ok_s  = pop && valid_r;

  // DEPTH is a power of two, so pointer wrap at DEPTH is the natural overflow.
  assign rd_ptr_inc_s = rd_ptr_r + PTR_W'(1);

  // Next occupancy and next head word. The head is a dedicated register so
  // that out_data is registered and keeps the last word after draining.
  always_comb begin
    level_nxt_s = level_r;
    head_nxt_s  = head_r;
    case ({push_ok_s, pop_ok_s})
      2'b10: begin
        level_nxt_s = level_r + LVL_W'(1);
        if (level_r == LVL_W'(0)) begin
          head_nxt_s = push_data;
        end else begin
          head_nxt_s = head_r;
        end
      end
      2'b01: begin
        level_nxt_s = level_r - LVL_W'(1);
        if (level_r > LVL_W'(1)) begin
          head_nxt_s = mem_r[rd_ptr_inc_s];
        end else begin
          head_nxt_s = head_r;
        end
      end
      2'b11: begin
        level_nxt_s = level_r;
        // With one entry the pushed word becomes the new head directly.
        if (level_r > LVL_W'(1)) begin
          head_nxt_s = mem_r[rd_ptr_inc_s];
        end else begin
          head_nxt_s = push_data;
        end
      end
      default: begin
        level_nxt_s = level_r;
        head_nxt_s  = head_r;
      end
    endcase
  end

  // Storage array; cleared on reset so no stale word can surface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy, head word and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      head_r   <= '0;
      ready_r  <= 1'b1;
      valid_r  <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_inc_s;
      end
      level_r <= level_nxt_s;
      head_r  <= head_nxt_s;
      ready_r <= (level_nxt_s < LVL_W'(DEPTH));
      valid_r <= (level_nxt_s != LVL_W'(0));
    end
  end

  assign in_ready  = ready_r;
  assign out_valid = valid_r;
  assign out_data  = head_r;
  assign level     = level_r;

endmodule

// File: rtl/gnet_remap.sv
// gnet_remap
//   Registered bus remapper. Each output bit is driven by CONST0, CONST1,
//   a selected input bit (PASS) or its own last emitted value (HOLD). The
//   per-bit map is written at run time; mapped words go through a FIFO.
//   Ports:
//     clk, rst_n               clock / asynchronous active-low reset
//     in_valid/in_ready/in_data    input word handshake
//     out_valid/out_ready/out_data FIFO head handshake
//     cfg_we, cfg_bit, cfg_mode, cfg_idx   map write port
//     cfg_err, cfg_err_clr     sticky illegal-write flag and its clear
//     fifo_level               FIFO occupancy
module gnet_remap
  import gnet_remap_pkg::*;
#(
  parameter  int IN_W  = 8,
  parameter  int OUT_W = 8,
  parameter  int DEPTH = 2,
  localparam int CB_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1,
  localparam int CI_W  = (IN_W > 1) ? $clog2(IN_W) : 1,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  input  logic             cfg_we,
  input  logic [CB_W-1:0]  cfg_bit,
  input  logic [1:0]       cfg_mode,
  input  logic [CI_W-1:0]  cfg_idx,
  output logic             cfg_err,
  input  logic             cfg_err_clr,
  output logic [LVL_W-1:0] fifo_level
);

  map_entry_t       map_r [OUT_W];
  map_entry_t       cfg_entry_s;
  logic [OUT_W-1:0] hold_r;
  logic [OUT_W-1:0] pass_s;
  logic [OUT_W-1:0] mapped_s;
  logic             cfg_err_r;
  logic             bit_bad_s;
  logic             idx_bad_s;
  logic             cfg_ok_s;
  logic             cfg_bad_s;
  logic             push_s;
  logic             fifo_ready_s;

  // Legality of a map write; both sides widened to 32 bits so the check
  // also covers select codes beyond a non-power-of-two width.
  assign bit_bad_s = (32'(cfg_bit) >= 32'(OUT_W));
  assign idx_bad_s = (cfg_mode == MODE_PASS) && (32'(cfg_idx) >= 32'(IN_W));
  assign cfg_ok_s  = cfg_we && !bit_bad_s && !idx_bad_s;
  assign cfg_bad_s = cfg_we && (bit_bad_s || idx_bad_s);

  // Entry to store; the index is kept only for PASS so other modes hold a
  // clean zero index.
  always_comb begin
    cfg_entry_s.mode = cfg_mode;
    if (cfg_mode == MODE_PASS) begin
      cfg_entry_s.idx = MAP_IDX_MAX_W'(cfg_idx);
    end else begin
      cfg_entry_s.idx = '0;
    end
  end

  // Map registers: identity at reset, one legal entry written per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_W; i++) begin
        map_r[i] <= map_reset_entry(i, IN_W);
      end
    end else begin
      for (int i = 0; i < OUT_W; i++) begin
        if (cfg_ok_s && (32'(cfg_bit) == 32'(i))) begin
          map_r[i] <= cfg_entry_s;
        end
      end
    end
  end

  // PASS source per output bit, built as an AND-OR select over all input
  // bits so an index can never read outside in_data or yield X.
  always_comb begin
    pass_s = '0;
    for (int i = 0; i < OUT_W; i++) begin
      for (int j = 0; j < IN_W; j++) begin
        pass_s[i] = pass_s[i] | (in_data[j] & (map_r[i].idx == MAP_IDX_MAX_W'(j)));
      end
    end
  end

  // Per-bit mapping mux using the map as it stands before this edge, so a
  // word accepted alongside a config write still sees the old map.
  always_comb begin
    mapped_s = '0;
    for (int i = 0; i < OUT_W; i++) begin
      case (map_r[i].mode)
        MODE_CONST0: mapped_s[i] = 1'b0;
        MODE_CONST1: mapped_s[i] = 1'b1;
        MODE_PASS:   mapped_s[i] = pass_s[i];
        MODE_HOLD:   mapped_s[i] = hold_r[i];
        default:     mapped_s[i] = 1'b0;
      endcase
    end
  end

  assign push_s = in_valid && fifo_ready_s;

  // Hold register captures the whole mapped word on every accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r <= '0;
    end else if (push_s) begin
      hold_r <= mapped_s;
    end
  end

  // Sticky config error; a new illegal write outranks a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_r <= 1'b0;
    end else if (cfg_bad_s) begin
      cfg_err_r <= 1'b1;
    end else if (cfg_err_clr) begin
      cfg_err_r <= 1'b0;
    end
  end

  gnet_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (mapped_s),
    .pop       (out_ready),
    .in_ready  (fifo_ready_s),
    .out_valid (out_valid),
    .out_data  (out_data),
    .level     (fifo_level)
  );

  assign in_ready = fifo_ready_s;
  assign cfg_err  = cfg_err_r;

endmodule

// File: tb/tb_gnet_remap.sv
// tb_gnet_remap
//   Self-checking bench for gnet_remap. Instance "a" (8 in / 8 out) is run
//   with directed scenarios and random traffic against a word-level
//   reference model (per-bit mode table, hold word, queue of pending words).
//   Instance "b" (6 in / 10 out) covers padding of upper bits and illegal
//   config writes, which the 3-bit select fields of an 8x8 map cannot encode.
module tb_gnet_remap;

  logic clk;
  logic rst_n;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic       a_cfg_we, a_cfg_err, a_cfg_err_clr;
  logic [2:0] a_cfg_bit, a_cfg_idx;
  logic [1:0] a_cfg_mode, a_fifo_level;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [5:0] b_in_data;
  logic [9:0] b_out_data;
  logic       b_cfg_we, b_cfg_err, b_cfg_err_clr;
  logic [3:0] b_cfg_bit;
  logic [2:0] b_cfg_idx;
  logic [1:0] b_cfg_mode, b_fifo_level;

  int n_chk;
  int n_pass;

  // Reference model state for instance a.
  int         m_mode [8];
  int         m_idx  [8];
  logic [7:0] m_hold;
  logic [7:0] m_q [$];
  logic [7:0] m_last;

  gnet_remap #(.IN_W(8), .OUT_W(8), .DEPTH(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .cfg_we(a_cfg_we), .cfg_bit(a_cfg_bit), .cfg_mode(a_cfg_mode), .cfg_idx(a_cfg_idx),
    .cfg_err(a_cfg_err), .cfg_err_clr(a_cfg_err_clr), .fifo_level(a_fifo_level)
  );

  gnet_remap #(.IN_W(6), .OUT_W(10), .DEPTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .cfg_we(b_cfg_we), .cfg_bit(b_cfg_bit), .cfg_mode(b_cfg_mode), .cfg_idx(b_cfg_idx),
    .cfg_err(b_cfg_err), .cfg_err_clr(b_cfg_err_clr), .fifo_level(b_fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 8; b++) begin
      m_mode[b] = 2;
      m_idx[b]  = b;
    end
    m_hold = 8'h00;
    m_q.delete();
    m_last = 8'h00;
  endtask

  // Word-level meaning of the map: each output bit from its mode.
  function automatic logic [7:0] model_map(input logic [7:0] d);
    logic [7:0] r;
    r = 8'h00;
    for (int b = 0; b < 8; b++) begin
      case (m_mode[b])
        0:       r[b] = 1'b0;
        1:       r[b] = 1'b1;
        2:       r[b] = d[m_idx[b]];
        default: r[b] = m_hold[b];
      endcase
    end
    return r;
  endfunction

  // One clock of instance a: drive, check ready, clock, update model, check.
  task automatic a_cycle(input logic iv, input logic [7:0] d, input logic ordy,
                         input logic we, input int cbit, input int mode,
                         input int cidx, input logic clr);
    logic       acc;
    logic       pop;
    logic [7:0] w;
    a_in_valid    = iv;
    a_in_data     = d;
    a_out_ready   = ordy;
    a_cfg_we      = we;
    a_cfg_bit     = 3'(cbit);
    a_cfg_mode    = 2'(mode);
    a_cfg_idx     = 3'(cidx);
    a_cfg_err_clr = clr;
    #1;
    chk("a_in_ready", 32'(a_in_ready), 32'(m_q.size() < 2));
    acc = iv && (m_q.size() < 2);
    pop = ordy && (m_q.size() > 0);
    w   = model_map(d);
    @(posedge clk);
    if (pop) begin
      void'(m_q.pop_front());
    end
    if (acc) begin
      m_q.push_back(w);
      m_hold = w;
    end
    if (we) begin
      m_mode[cbit] = mode;
      m_idx[cbit]  = cidx;
    end
    #1;
    if (m_q.size() > 0) begin
      m_last = m_q[0];
    end
    chk("a_out_valid", 32'(a_out_valid), 32'(m_q.size() > 0));
    chk("a_out_data", 32'(a_out_data), 32'(m_last));
    chk("a_fifo_level", 32'(a_fifo_level), 32'(m_q.size()));
    chk("a_cfg_err", 32'(a_cfg_err), 32'd0);
  endtask

  task automatic b_cycle(input logic iv, input logic [5:0] d, input logic we,
                         input int cbit, input int mode, input int cidx, input logic clr);
    b_in_valid    = iv;
    b_in_data     = d;
    b_out_ready   = 1'b1;
    b_cfg_we      = we;
    b_cfg_bit     = 4'(cbit);
    b_cfg_mode    = 2'(mode);
    b_cfg_idx     = 3'(cidx);
    b_cfg_err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b0; a_cfg_we = 1'b0;
    a_cfg_bit = 3'd0; a_cfg_mode = 2'd0; a_cfg_idx = 3'd0; a_cfg_err_clr = 1'b0;
    b_in_valid = 1'b0; b_in_data = 6'h00; b_out_ready = 1'b0; b_cfg_we = 1'b0;
    b_cfg_bit = 4'd0; b_cfg_mode = 2'd0; b_cfg_idx = 3'd0; b_cfg_err_clr = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #12;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_data", 32'(a_out_data), 32'd0);
    chk("rst_level", 32'(a_fifo_level), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_cfg_err", 32'(a_cfg_err), 32'd0);
    chk("rst_b_out_data", 32'(b_out_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Instance b: upper bits padded with 0, illegal writes, error clear.
    b_cycle(1'b1, 6'h2A, 1'b0, 0, 0, 0, 1'b0);
    chk("b_pad", 32'(b_out_data), 32'h02A);
    chk("b_valid", 32'(b_out_valid), 32'd1);
    b_cycle(1'b0, 6'h00, 1'b1, 0, 2, 7, 1'b0);
    chk("b_err_idx", 32'(b_cfg_err), 32'd1);
    b_cycle(1'b1, 6'h01, 1'b0, 0, 0, 0, 1'b0);
    chk("b_map_kept", 32'(b_out_data), 32'h001);
    b_cycle(1'b0, 6'h00, 1'b0, 0, 0, 0, 1'b1);
    chk("b_err_clr", 32'(b_cfg_err), 32'd0);
    b_cycle(1'b0, 6'h00, 1'b1, 12, 1, 0, 1'b0);
    chk("b_err_bit", 32'(b_cfg_err), 32'd1);
    b_cycle(1'b0, 6'h00, 1'b0, 0, 0, 0, 1'b1);
    b_cycle(1'b0, 6'h00, 1'b1, 12, 1, 0, 1'b1);
    chk("b_set_wins", 32'(b_cfg_err), 32'd1);
    b_cycle(1'b0, 6'h00, 1'b0, 0, 0, 0, 1'b1);
    chk("b_err_clr2", 32'(b_cfg_err), 32'd0);
    b_cycle(1'b0, 6'h00, 1'b1, 9, 1, 7, 1'b0);
    chk("b_idx_ignored", 32'(b_cfg_err), 32'd0);
    b_cycle(1'b0, 6'h00, 1'b1, 8, 2, 5, 1'b0);
    chk("b_pass_max", 32'(b_cfg_err), 32'd0);
    b_cycle(1'b1, 6'h20, 1'b0, 0, 0, 0, 1'b0);
    chk("b_wide_map", 32'(b_out_data), 32'h320);
    b_cycle(1'b0, 6'h00, 1'b0, 0, 0, 0, 1'b0);

    // Basic push/pop with identity map.
    a_cycle(1'b1, 8'hA5, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    chk("a5_data", 32'(a_out_data), 32'hA5);
    chk("a5_level", 32'(a_fifo_level), 32'd1);
    a_cycle(1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    chk("a5_drained", 32'(a_fifo_level), 32'd0);

    // Config write in the accepting cycle uses the old map.
    a_cycle(1'b1, 8'h3C, 1'b1, 1'b1, 7, 1, 0, 1'b0);
    chk("old_map", 32'(a_out_data), 32'h3C);
    a_cycle(1'b0, 8'h00, 1'b1, 1'b1, 6, 0, 0, 1'b0);
    a_cycle(1'b1, 8'h3C, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    chk("const_map", 32'(a_out_data), 32'hBC);
    a_cycle(1'b0, 8'h00, 1'b1, 1'b1, 7, 2, 7, 1'b0);
    a_cycle(1'b0, 8'h00, 1'b1, 1'b1, 6, 2, 6, 1'b0);

    // HOLD bits keep their last pushed value.
    a_cycle(1'b1, 8'hFF, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    chk("hold_ff", 32'(a_out_data), 32'hFF);
    a_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1, 3, 0, 1'b0);
    a_cycle(1'b0, 8'h00, 1'b1, 1'b1, 0, 3, 0, 1'b0);
    a_cycle(1'b1, 8'h00, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    chk("hold_03", 32'(a_out_data), 32'h03);
    a_cycle(1'b1, 8'h00, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    chk("hold_03b", 32'(a_out_data), 32'h03);
    a_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1, 2, 1, 1'b0);
    a_cycle(1'b0, 8'h00, 1'b1, 1'b1, 0, 2, 0, 1'b0);

    // Backpressure: fill, refuse third word, then drain in order.
    a_cycle(1'b1, 8'h01, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    a_cycle(1'b1, 8'h02, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    chk("full_ready", 32'(a_in_ready), 32'd0);
    a_cycle(1'b1, 8'h03, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    chk("full_head", 32'(a_out_data), 32'h01);
    a_cycle(1'b1, 8'h03, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    chk("order_02", 32'(a_out_data), 32'h02);
    a_cycle(1'b1, 8'h03, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    chk("order_03", 32'(a_out_data), 32'h03);
    a_cycle(1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 0, 1'b0);

    // Mid-cycle reset with a full FIFO and non-identity map.
    a_cycle(1'b0, 8'h00, 1'b1, 1'b1, 7, 1, 0, 1'b0);
    a_cycle(1'b1, 8'h01, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    a_cycle(1'b1, 8'h02, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(a_out_valid), 32'd0);
    chk("arst_level", 32'(a_fifo_level), 32'd0);
    chk("arst_ready", 32'(a_in_ready), 32'd1);
    model_reset();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(a_out_valid), 32'd0);
    a_cycle(1'b1, 8'h5A, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    chk("identity_back", 32'(a_out_data), 32'h5A);

    // Random traffic and map writes against the model.
    for (int n = 0; n < 600; n++) begin
      a_cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 6) == 0), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
